// File: rtl/key_scan_pkg.sv
// Shared keypad-scanner types: FSM states, row drive patterns, default timing.
// Pure definitions; no latency or flow control.
package key_scan_pkg;

  localparam int SCAN_CNTMAX_DEF    = 24999;
  localparam int DEBOUNCE_TICKS_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_SCAN,
    ST_HOLD,
    ST_RELEASE_DB
  } state_t;

  // Row drive patterns for row index 3..0, one low bit selects the row.
  localparam logic [15:0] ROW_PATTERNS = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ROW_PATTERNS[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [1:0] lowest_col(input logic [3:0] col);
    logic [1:0] res;
    res = 2'd3;
    for (int c = 3; c >= 0; c--) begin
      if (!col[c]) res = 2'(c);
    end
    return res;
  endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Free-running scan tick: one-clk pulse every SCAN_CNTMAX+1 clocks.
// Tick is combinational from the counter wrap; no backpressure.
module key_tick_gen
  import key_scan_pkg::*;
#(
  parameter int SCAN_CNTMAX = SCAN_CNTMAX_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_CNTMAX > 0) ? $clog2(SCAN_CNTMAX + 1) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SCAN_CNTMAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: synchronise columns, debounce press/release, scan rows, report key code.
// Latency: 2 sync clocks + up to 1 tick + DEBOUNCE_TICKS + (row+1) ticks; no backpressure on outputs.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_CNTMAX    = SCAN_CNTMAX_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  logic [3:0]    col_m;
  logic [3:0]    col_s;
  logic          tick;
  state_t        state;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_next;
  logic [1:0]    row_idx;
  logic          col_idle;

  key_tick_gen #(.SCAN_CNTMAX(SCAN_CNTMAX)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Columns are pulled up and asynchronous; idle value is all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= key_col;
      col_s <= col_m;
    end
  end

  assign col_idle = (col_s == 4'hF);
  assign db_next  = db_cnt + DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      db_cnt      <= '0;
      row_idx     <= 2'd0;
      key_row     <= 4'b0000;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (!col_idle) begin
              state  <= ST_PRESS_DB;
              db_cnt <= '0;
            end
          end
          ST_PRESS_DB: begin
            if (col_idle) begin
              state <= ST_IDLE;
            end else begin
              db_cnt <= db_next;
              if (db_next == DW'(DEBOUNCE_TICKS)) begin
                state   <= ST_SCAN;
                row_idx <= 2'd0;
                key_row <= row_drive(2'd0);
              end
            end
          end
          ST_SCAN: begin
            if (!col_idle) begin
              // Hit: keep this row driven so release is watched on it alone.
              key_code    <= {row_idx, lowest_col(col_s)};
              key_valid   <= 1'b1;
              key_pressed <= 1'b1;
              state       <= ST_HOLD;
            end else if (row_idx == 2'd3) begin
              state   <= ST_IDLE;
              key_row <= 4'b0000;
            end else begin
              row_idx <= row_idx + 2'd1;
              key_row <= row_drive(row_idx + 2'd1);
            end
          end
          ST_HOLD: begin
            if (col_idle) begin
              state  <= ST_RELEASE_DB;
              db_cnt <= '0;
            end
          end
          ST_RELEASE_DB: begin
            if (!col_idle) begin
              state <= ST_HOLD;
            end else begin
              db_cnt <= db_next;
              if (db_next == DW'(DEBOUNCE_TICKS)) begin
                key_pressed <= 1'b0;
                key_row     <= 4'b0000;
                state       <= ST_IDLE;
              end
            end
          end
          default: begin
            state   <= ST_IDLE;
            key_row <= 4'b0000;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter SCAN_CNTMAX, default 24999: tick period minus one, in clk cycles (one tick = SCAN_CNTMAX+1 clocks).
REQ-002 Parameter DEBOUNCE_TICKS, default 20: number of consecutive stable ticks required for press and release.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_col  input  4  keypad column lines, active-low (pulled up), asynchronous to clk.
REQ-006 key_row  output  4  keypad row drive, active-low.
REQ-007 key_code  output  4  code of the last accepted key, = row_index*4 + col_index.
REQ-008 key_valid  output  1  one-clk pulse when a new key_code is accepted.
REQ-009 key_pressed  output  1  high from acceptance until release is debounced.

Function
REQ-010 key_col SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value (col_s).
REQ-011 A free-running tick counter SHALL count 0..SCAN_CNTMAX and emit a one-clk tick on wrap; the FSM advances only on tick.
REQ-012 FSM states: IDLE, PRESS_DB, SCAN, HOLD, RELEASE_DB.
REQ-013 IDLE: key_row = 4'b0000; on tick with col_s != 4'hF -> PRESS_DB, debounce count cleared.
REQ-014 PRESS_DB: key_row = 4'b0000; each tick with col_s != 4'hF increments count; tick with col_s == 4'hF -> IDLE (bounce, no output); count reaching DEBOUNCE_TICKS -> SCAN, row index 0.
REQ-015 SCAN: key_row drives 1110, 1101, 1011, 0111 for row index 0..3, one row per tick; col_s is sampled on the tick ending each row.
REQ-016 SCAN hit (col_s != 4'hF): key_code <= row*4 + lowest-index low column; key_valid = 1 for exactly one clk; key_pressed <= 1; -> HOLD with that row still driven.
REQ-017 SCAN with no hit after row 3 -> IDLE; no key_valid, key_code unchanged.
REQ-018 HOLD: key_row stays on the hit row; tick with col_s == 4'hF -> RELEASE_DB, count cleared; a second key pressed meanwhile is ignored (no rollover).
REQ-019 RELEASE_DB: each tick with col_s == 4'hF increments count; tick with col_s != 4'hF -> HOLD; count reaching DEBOUNCE_TICKS -> key_pressed <= 0, -> IDLE.
REQ-020 key_code SHALL hold its value between key_valid pulses.
REQ-021 Press-to-key_valid latency: 2 sync clocks + at most 1 tick wait + DEBOUNCE_TICKS ticks + (row_index+1) ticks.
REQ-022 Debounce counter SHALL be sized to hold DEBOUNCE_TICKS without wrap.

Reset
REQ-023 With rst high at a clk edge: state = IDLE, tick counter = 0, debounce count = 0, synchroniser flops = 4'hF, key_row = 4'b0000, key_code = 4'h0, key_valid = 0, key_pressed = 0.
REQ-024 Reset mid-operation (any state) SHALL abort without emitting key_valid; operation restarts from IDLE on the first clk after rst falls.

Structure
REQ-025 Shared package key_scan_pkg SHALL hold the state enumeration, the four row-drive patterns, and default SCAN_CNTMAX/DEBOUNCE_TICKS.
REQ-026 Tick generation SHALL be the sub-module key_tick_gen (parameter SCAN_CNTMAX; ports clk, rst, tick); FSM, debounce and synchroniser stay in key_scan.

Verification (SCAN_CNTMAX=3, DEBOUNCE_TICKS=2, keypad model connects row r to column c when key (r,c) is down)
REQ-027 Clean press of key (2,1) held 20 ticks -> one key_valid pulse, key_code = 4'h9, key_pressed high until 2 ticks after release.
REQ-028 Press of (0,3) lasting 1 tick -> return to IDLE, no key_valid, key_code unchanged at 4'h0.
REQ-029 Keys (1,2) and (1,0) pressed together -> key_code = 4'h4 (lowest column wins), single pulse.
REQ-030 Hold (3,3), bounce release for 1 tick then press again, stay 10 ticks, release -> one key_valid (code 4'hF), key_pressed never drops during bounce.
REQ-031 Assert rst for 1 clk while in SCAN on row 2 with key (2,0) down -> no key_valid, all outputs at reset values, re-detection yields key_code = 4'h8.
REQ-032 Hold (0,0), press (3,3) in HOLD, release (0,0) -> no second key_valid until full release then re-press.
